// File: rtl/fu_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fu_cfg_sequencer_if
//  Description : Configuration-load stream between the array config network
//                (master) and one FU configuration sequencer (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface fu_cfg_sequencer_if #(
    parameter int CFG_WIDTH = 4
);
    logic                 load_req;
    logic                 cfg_valid;
    logic [CFG_WIDTH-1:0] cfg_data;
    logic                 cfg_last;
    logic                 cfg_ready;
    logic                 load_done;

    modport master (
        output load_req, cfg_valid, cfg_data, cfg_last,
        input  cfg_ready, load_done
    );

    modport slave (
        input  load_req, cfg_valid, cfg_data, cfg_last,
        output cfg_ready, load_done
    );
endinterface
`default_nettype wire

// File: rtl/fu_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fu_cfg_sequencer
//  Description : Loads up to NUM_CTX configuration contexts over a valid/ready
//                stream and replays them cyclically onto one FU's config input.
//  Revision    : 1.0  initial release
// ============================================================================
module fu_cfg_sequencer #(
    parameter int CFG_WIDTH = 4,
    parameter int NUM_CTX   = 8,
    parameter int CTX_AW    = 3,
    parameter int IDLE_CFG  = 15
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    fu_cfg_sequencer_if.slave         cfg,
    input  wire logic                 start,
    input  wire logic                 stop,
    output logic      [CFG_WIDTH-1:0] config_sig,
    output logic      [CTX_AW-1:0]    ctx_idx,
    output logic                      running
);

    localparam logic [CFG_WIDTH-1:0] c_idle_word = CFG_WIDTH'(IDLE_CFG);
    localparam logic [CTX_AW-1:0]    c_last_ptr  = CTX_AW'(NUM_CTX - 1);
    localparam logic [CTX_AW:0]      c_one       = (CTX_AW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t               state_q,      state_d;
    logic [CTX_AW-1:0]    wptr_q,       wptr_d;
    logic [CTX_AW:0]      ctx_count_q,  ctx_count_d;
    logic [CFG_WIDTH-1:0] mem_q [NUM_CTX];
    logic [CFG_WIDTH-1:0] mem_d [NUM_CTX];
    logic [CFG_WIDTH-1:0] config_sig_q, config_sig_d;
    logic [CTX_AW-1:0]    ctx_idx_q,    ctx_idx_d;
    logic                 running_q,    running_d;
    logic                 load_done_q,  load_done_d;

    logic [CTX_AW:0]      w_idx_inc;
    logic [CTX_AW-1:0]    w_idx_next;
    logic                 w_accept;

    // ctx_count is one bit wider than the index so a full set (NUM_CTX) fits.
    assign w_idx_inc  = {1'b0, ctx_idx_q} + c_one;
    assign w_idx_next = (w_idx_inc == ctx_count_q) ? '0 : w_idx_inc[CTX_AW-1:0];
    assign w_accept   = cfg.cfg_valid && (state_q == ST_LOAD);

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        ctx_count_d  = ctx_count_q;
        mem_d        = mem_q;
        config_sig_d = config_sig_q;
        ctx_idx_d    = ctx_idx_q;
        running_d    = running_q;
        load_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg.load_req) begin
                    state_d = ST_LOAD;
                    wptr_d  = '0;
                end else if (start && (ctx_count_q != '0)) begin
                    state_d      = ST_RUN;
                    config_sig_d = mem_q[0];
                    ctx_idx_d    = '0;
                    running_d    = 1'b1;
                end
            end

            ST_LOAD: begin
                if (w_accept) begin
                    mem_d[wptr_q] = cfg.cfg_data;
                    wptr_d        = wptr_q + CTX_AW'(1);
                    // A full memory terminates the set even without cfg_last.
                    if (cfg.cfg_last || (wptr_q == c_last_ptr)) begin
                        ctx_count_d = {1'b0, wptr_q} + c_one;
                        state_d     = ST_IDLE;
                        load_done_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d      = ST_IDLE;
                    config_sig_d = c_idle_word;
                    ctx_idx_d    = '0;
                    running_d    = 1'b0;
                end else begin
                    ctx_idx_d    = w_idx_next;
                    config_sig_d = mem_q[w_idx_next];
                end
            end

            default: begin
                state_d      = ST_IDLE;
                config_sig_d = c_idle_word;
                ctx_idx_d    = '0;
                running_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wptr_q       <= '0;
            ctx_count_q  <= '0;
            config_sig_q <= c_idle_word;
            ctx_idx_q    <= '0;
            running_q    <= 1'b0;
            load_done_q  <= 1'b0;
            for (int i = 0; i < NUM_CTX; i++) begin
                mem_q[i] <= c_idle_word;
            end
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            ctx_count_q  <= ctx_count_d;
            config_sig_q <= config_sig_d;
            ctx_idx_q    <= ctx_idx_d;
            running_q    <= running_d;
            load_done_q  <= load_done_d;
            for (int i = 0; i < NUM_CTX; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign cfg.cfg_ready = (state_q == ST_LOAD);
    assign cfg.load_done = load_done_q;
    assign config_sig    = config_sig_q;
    assign ctx_idx       = ctx_idx_q;
    assign running       = running_q;

endmodule
`default_nettype wire
